// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with
// 1-cycle registered read data. Tracks occupancy, status and sticky error flags.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_WIDTH:0] af_level_c = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] ptr_one_c  = (ADDR_WIDTH+1)'(1);

  // One extra pointer bit distinguishes full from empty when the addresses match.
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                push_ok, pop_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                 (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
  assign count       = wptr_q - rptr_q;
  assign almost_full = (count >= af_level_c);

  // Requests are judged against the current-cycle flags and ignored in reset.
  assign push_ok = wr_en && !full  && !rst;
  assign pop_ok  = rd_en && !empty && !rst;

  assign ram_we         = push_ok;
  assign ram_data_in    = wr_data;
  assign ram_write_addr = wptr_q[ADDR_WIDTH-1:0];
  assign ram_read_addr  = rptr_q[ADDR_WIDTH-1:0];
  assign rd_data        = ram_data_out;
  assign rd_valid       = rd_valid_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rd_valid_d  = pop_ok;
    overflow_d  = overflow_q  | (wr_en && full);
    underflow_d = underflow_q | (rd_en && empty);
    if (push_ok) wptr_d = wptr_q + ptr_one_c;
    if (pop_ok)  rptr_d = rptr_q + ptr_one_c;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl with a behavioural registered-read RAM.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       ram_we;
  logic [3:0] ram_write_addr;
  logic [3:0] ram_read_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data_in;
    ram_data_out <= mem[ram_read_addr];
  end

  typedef struct {
    logic       rst, wr, rd;
    logic [7:0] wdata;
    logic       we;
    logic [3:0] waddr, raddr;
    logic [4:0] cnt;
    logic       full, empty, af;
    logic       rv;
    logic [7:0] rdata;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] wd,
                     input logic we, input logic [3:0] wa, input logic [3:0] ra,
                     input logic [4:0] cnt, input logic ovf, input logic unf,
                     input logic rv, input logic [7:0] rdat);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.wdata = wd;
    v.we = we; v.waddr = wa; v.raddr = ra; v.cnt = cnt;
    v.full = (cnt == 5'd16); v.empty = (cnt == 5'd0); v.af = (cnt >= 5'd14);
    v.rv = rv; v.rdata = rdat; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic w, input logic rd, input logic [7:0] wd);
    rst = r; wr_en = w; rd_en = rd; wr_data = wd;
  endtask

  initial begin
    logic [7:0] exp_d;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;

    // Reset with both requests asserted: no RAM write, state cleared
    add(1, 1, 1, 8'hFF, 0, 4'd0, 4'd0, 5'd0, 0, 0, 0, 8'h00);
    // Fill 0x01..0x10
    for (int i = 0; i < 16; i++)
      add(0, 1, 0, 8'(i+1), 1, 4'(i), 4'd0, 5'(i+1), 0, 0, 0, 8'h00);
    // Drain back-to-back
    for (int i = 0; i < 16; i++)
      add(0, 0, 1, 8'h00, 0, 4'd0, 4'(i), 5'(15-i), 0, 0, 1, 8'(i+1));
    add(0, 0, 0, 8'h00, 0, 4'd0, 4'd0, 5'd0, 0, 0, 0, 8'h00);
    // Prime to count=3, then 40 push/pop pairs across the address wrap
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'(8'hA0+i), 1, 4'(i), 4'd0, 5'(i+1), 0, 0, 0, 8'h00);
    for (int k = 0; k < 40; k++) begin
      exp_d = (k < 3) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 3);
      add(0, 1, 1, 8'(8'hB0+k), 1, 4'((3+k) % 16), 4'(k % 16), 5'd3, 0, 0, 1, exp_d);
    end
    for (int i = 0; i < 3; i++)
      add(0, 0, 1, 8'h00, 0, 4'd0, 4'(8+i), 5'(2-i), 0, 0, 1, 8'(8'hD5+i));
    // Both requests while empty: push only, underflow sticks
    add(0, 1, 1, 8'h5A, 1, 4'd11, 4'd11, 5'd1, 0, 1, 0, 8'h00);
    for (int j = 0; j < 15; j++)
      add(0, 1, 0, 8'(8'h60+j), 1, 4'((12+j) % 16), 4'd11, 5'(2+j), 0, 1, 0, 8'h00);
    // Both requests while full: pop only, overflow sticks
    add(0, 1, 1, 8'h77, 0, 4'd0, 4'd11, 5'd15, 1, 1, 1, 8'h5A);
    add(0, 0, 0, 8'h00, 0, 4'd0, 4'd12, 5'd15, 1, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 8'h00, 0, 4'd0, 4'((12+i) % 16), 5'(14-i), 1, 1, 1, 8'(8'h60+i));
    // Reset at count=7 with a pop request pending
    add(1, 0, 1, 8'h00, 0, 4'd0, 4'd4, 5'd0, 0, 0, 0, 8'h00);
    add(0, 1, 0, 8'h33, 1, 4'd0, 4'd0, 5'd1, 0, 0, 0, 8'h00);
    add(0, 0, 1, 8'h00, 0, 4'd0, 4'd0, 5'd0, 0, 0, 1, 8'h33);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
      #1;
      check($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d ram_write_addr", i), 32'(ram_write_addr), 32'(vecs[i].waddr));
        check($sformatf("v%0d ram_data_in", i), 32'(ram_data_in), 32'(vecs[i].wdata));
      end
      check($sformatf("v%0d ram_read_addr", i), 32'(ram_read_addr), 32'(vecs[i].raddr));
      @(posedge clk); #1;
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].empty));
      check($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].af));
      check($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      if (vecs[i].rv)
        check($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rdata));
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
    end

    // Lone pop on empty sets underflow only; it must survive idle cycles
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("lone_pop underflow", 32'(underflow), 32'd1);
    check("lone_pop overflow", 32'(overflow), 32'd0);
    check("lone_pop rd_valid", 32'(rd_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("lone_pop underflow sticky", 32'(underflow), 32'd1);

    // Lone push on full: no RAM write, overflow sets, count held at depth
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(8'hC0+i));
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b1, 1'b0, 8'hEE);
    #1;
    check("push_full ram_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("push_full overflow", 32'(overflow), 32'd1);
    check("push_full count", 32'(count), 32'd16);
    check("push_full full", 32'(full), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the word width and matches the attached RAM.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, which sets the RAM address width; depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter AF_LEVEL, default 2**ADDR_WIDTH-2, which sets the almost_full threshold in words.
REQ-004 Port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port wr_en, input, 1 bit: push request.
REQ-007 Port wr_data, input, DATA_WIDTH bits: push data.
REQ-008 Port rd_en, input, 1 bit: pop request.
REQ-009 Port rd_data, output, DATA_WIDTH bits: popped word.
REQ-010 Port rd_valid, output, 1 bit: rd_data holds a popped word.
REQ-011 Ports full, empty and almost_full are outputs, 1 bit each: status flags.
REQ-012 Port count, output, ADDR_WIDTH+1 bits: occupancy.
REQ-013 Ports overflow and underflow are outputs, 1 bit each: sticky error flags.
REQ-014 Port ram_we, output, 1 bit: write enable to the dual-port RAM.
REQ-015 Port ram_write_addr, output, ADDR_WIDTH bits: RAM write address.
REQ-016 Port ram_read_addr, output, ADDR_WIDTH bits: RAM read address.
REQ-017 Port ram_data_in, output, DATA_WIDTH bits: RAM write data.
REQ-018 Port ram_data_out, input, DATA_WIDTH bits: RAM registered read data, valid 1 cycle after the address is presented.

Function
REQ-019 wptr and rptr SHALL be ADDR_WIDTH+1-bit registers; ram_write_addr and ram_read_addr SHALL equal their low ADDR_WIDTH bits, combinationally.
REQ-020 A push SHALL be accepted when wr_en=1 and full=0, judged on the current-cycle full.
REQ-021 On an accepted push, ram_we SHALL be 1 in that cycle, ram_data_in SHALL equal wr_data, and wptr SHALL increment at the edge.
REQ-022 ram_we SHALL be 0 whenever no push is accepted.
REQ-023 A pop SHALL be accepted when rd_en=1 and empty=0, judged on the current-cycle empty, and rptr SHALL increment at the edge.
REQ-024 rd_valid SHALL be a register set to 1 in the cycle after an accepted pop and 0 otherwise, giving 1-cycle read latency.
REQ-025 rd_data SHALL pass ram_data_out through combinationally.
REQ-026 empty SHALL be 1 when wptr==rptr.
REQ-027 full SHALL be 1 when the pointer MSBs differ and the low bits are equal.
REQ-028 count SHALL equal wptr-rptr, modulo 2**(ADDR_WIDTH+1), with range 0..2**ADDR_WIDTH.
REQ-029 almost_full SHALL be 1 when count>=AF_LEVEL.
REQ-030 Pointers SHALL wrap from 2**(ADDR_WIDTH+1)-1 to 0 with no special handling; low address bits wrap from 2**ADDR_WIDTH-1 to 0.
REQ-031 Simultaneous push and pop with 0<count<depth SHALL both be accepted, leaving count unchanged.
REQ-032 Simultaneous push and pop when full SHALL accept the pop only; the push is dropped and overflow is set.
REQ-033 Simultaneous push and pop when empty SHALL accept the push only; the pop is dropped and underflow is set.
REQ-034 wr_en=1 while full SHALL set overflow, which holds until rst.
REQ-035 rd_en=1 while empty SHALL set underflow, which holds until rst.
REQ-036 ram_write_addr SHALL never equal ram_read_addr in a cycle where both a push and a pop are accepted; this follows from the flag rules and needs no extra logic.

Reset
REQ-037 While rst=1 at an edge, wptr, rptr, rd_valid, overflow and underflow SHALL be cleared to 0, giving empty=1, full=0, almost_full=0 and count=0.
REQ-038 ram_we SHALL be 0 during any cycle with rst=1, and push and pop requests in that cycle SHALL be ignored.
REQ-039 Reset mid-operation SHALL discard all stored words and suppress any rd_valid pending from a pop in the reset cycle; RAM contents are not cleared.

Verification
REQ-040 Reset then fill: push 0x01..0x10 on 16 consecutive cycles -> full=1 after the 16th edge, count=16, almost_full=1 from count=14, ram_we pulses on addresses 0..15.
REQ-041 Drain: pop 16 times back-to-back -> rd_valid=1 on cycles 2..17 with rd_data 0x01..0x10 in order, then empty=1 and count=0.
REQ-042 Wrap: 40 interleaved push/pop pairs starting at count=3 -> count stays 3, addresses wrap past 15, and data order is preserved.
REQ-043 Full with both requests: wr_en=1 and rd_en=1 at count=16 -> count=15, ram_we=0, overflow=1 and stays 1.
REQ-044 Empty with both requests: wr_en=1 and rd_en=1 at count=0 -> count=1, rd_valid=0 next cycle, underflow=1.
REQ-045 Reset mid-run: assert rst at count=7 together with rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, flags cleared.
